// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator that programs the UART register
// slave.
//   - apb_state_t        : transfer FSM encoding (IDLE, SETUP, ACCESS, RESP)
//   - APB_ADDR_W/DATA_W  : default bus widths (4 registers of 8 bits)
//   - REG_BAUD/REG_TXDATA: UART register addresses used by the controller
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 2;
    localparam int APB_DATA_W = 8;

    // UART register map as seen from this initiator
    localparam logic [APB_ADDR_W-1:0] REG_BAUD   = 2'd0;
    localparam logic [APB_ADDR_W-1:0] REG_TXDATA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles in which the slave holds pready low and flags when the
// wait limit is reached. Only instantiated when APB_TIMEOUT_EN is defined.
//
// Ports
//   pclk     in  APB clock (rising edge)
//   presetn  in  asynchronous active-low reset, clears the count
//   clear    in  restart the count (asserted in the cycle before ACCESS)
//   incr     in  one more wait cycle observed
//   expired  out count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int                 CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT; the FSM leaves ACCESS as soon as the limit is seen,
    // so the hold only matters if pready and the limit coincide.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (incr && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB initiator: converts a valid/ready command interface into APB SETUP and
// ACCESS phases toward the UART register slave, one transfer at a time, and
// returns a single-cycle response pulse. All outputs are registered.
//
// Optional feature: define APB_TIMEOUT_EN to abort transfers whose ACCESS
// phase lasts TIMEOUT_CYC cycles without pready (rsp_err = 1, rsp_rdata = 0).
// Without it the initiator waits for pready indefinitely and rsp_err stays 0.
//
// Ports
//   pclk, presetn        clock (rising edge) / asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; accepted when both are high
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  register address and write data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            read data (unchanged by writes)
//   rsp_err              transfer aborted by timeout
//   psel, penable, pwrite, paddr, pwdata   APB request outputs
//   prdata, pready       APB slave response inputs
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYC must be at least 1");
    end

    apb_state_t        state, state_n;
    logic              cmd_ready_n;
    logic              psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n;
    logic              rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              wait_expired;

`ifdef APB_TIMEOUT_EN
    logic timer_clear;
    logic timer_incr;

    // Clearing while in SETUP means the count is zero on the first ACCESS cycle.
    assign timer_clear = (state == ST_SETUP);
    assign timer_incr  = (state == ST_ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (timer_clear),
        .incr    (timer_incr),
        .expired (wait_expired)
    );
`else
    // No limit: the abort branch below becomes unreachable and rsp_err
    // reduces to a constant 0.
    assign wait_expired = 1'b0;
`endif

    // State and every output are plain registers; reset drops psel/penable
    // immediately, which also discards any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= cmd_ready_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    // Next state and next register values. Address/data registers hold by
    // default so paddr/pwdata keep their last values between transfers.
    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = rsp_rdata;

        case (state)
            ST_IDLE: begin
                cmd_ready_n = 1'b1;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                if (cmd_valid) begin
                    // pwdata is captured for reads as well; the slave ignores it.
                    pwrite_n    = cmd_write;
                    paddr_n     = cmd_addr;
                    pwdata_n    = cmd_wdata;
                    cmd_ready_n = 1'b0;
                    psel_n      = 1'b1;
                    state_n     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                psel_n    = 1'b1;
                penable_n = 1'b1;
                state_n   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // pready completing on the limit cycle takes priority over abort.
                if (pready) begin
                    if (!pwrite) begin
                        rsp_rdata_n = prdata;
                    end
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    state_n     = ST_RESP;
                end else if (wait_expired) begin
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                    state_n     = ST_RESP;
                end
            end

            ST_RESP: begin
                cmd_ready_n = 1'b1;
                state_n     = ST_IDLE;
            end

            default: begin
                cmd_ready_n = 1'b1;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                state_n     = ST_IDLE;
            end
        endcase
    end

endmodule : apb_master

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Randomised bench for apb_master with a behavioural slave (4-entry register
// file), a transaction-level reference model and a scoreboard monitor.
// Honours APB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            psel_cyc;
        int            pen_cyc;
    } rsp_t;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    rsp_t          rsp_q[$];   // expected responses, in issue order
    cmd_t          mon_q[$];   // expected bus contents per transfer
    int            wait_q[$];  // slave wait states per transfer (<0: never ready)
    logic [DW-1:0] smem[4];    // slave register file (driven by the bus)
    logic [DW-1:0] mmem[4];    // reference model register file
    logic [DW-1:0] last_rd;    // model of rsp_rdata between reads

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural APB slave ----------------
    initial begin
        int wl;
        wl     = 0;
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                pready = 1'b0;
                wl     = 0;
            end else if (psel && !penable) begin
                wl     = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                pready = 1'($urandom);   // must be ignored outside ACCESS
                prdata = 8'($urandom);
            end else if (psel && penable) begin
                if (wl == 0) begin
                    pready = 1'b1;
                    if (pwrite) smem[paddr] = pwdata;
                    else        prdata      = smem[paddr];
                end else begin
                    pready = 1'b0;
                    prdata = 8'($urandom);
                    if (wl > 0) wl--;
                end
            end else begin
                pready = 1'($urandom);
                prdata = 8'($urandom);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        cmd_t cur;
        rsp_t e;
        int   ps, pe;
        logic prev_rsp;
        cur.w = 1'b0; cur.a = '0; cur.d = '0;
        ps = 0; pe = 0; prev_rsp = 1'b0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                ps = 0; pe = 0; prev_rsp = 1'b0;
            end else begin
                if (prev_rsp) begin
                    chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
                    chk("ready_after_resp", 32'(cmd_ready), 32'd1);
                end
                if (psel && !penable) begin
                    if (mon_q.size() == 0) begin
                        chk("unexpected_setup", 32'd1, 32'd0);
                    end else begin
                        cur = mon_q.pop_front();
                    end
                    chk("ready_low_in_setup", 32'(cmd_ready), 32'd0);
                end
                if (psel) begin
                    ps++;
                    chk("paddr", 32'(paddr), 32'(cur.a));
                    chk("pwrite", 32'(pwrite), 32'(cur.w));
                    chk("pwdata", 32'(pwdata), 32'(cur.d));
                    chk("ready_low_in_xfer", 32'(cmd_ready), 32'd0);
                end
                if (penable) begin
                    pe++;
                    chk("penable_needs_psel", 32'(psel), 32'd1);
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        chk("psel_cycles", 32'(ps), 32'(e.psel_cyc));
                        chk("penable_cycles", 32'(pe), 32'(e.pen_cyc));
                    end
                    chk("psel_low_in_resp", 32'(psel), 32'd0);
                    chk("ready_low_in_resp", 32'(cmd_ready), 32'd0);
                    ps = 0; pe = 0;
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    // Present a command and hold it until accepted. Enters and leaves #1 after
    // a rising edge; cmd_valid is left high so callers can chain commands.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input bit push_rsp);
        int   n;
        int   acc;
        bit   tmo;
        cmd_t c;
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        c.w = w; c.a = a; c.d = d;
        mon_q.push_back(c);
        wait_q.push_back(waits);
        if (push_rsp) begin
            acc = waits + 1;
`ifdef APB_TIMEOUT_EN
            tmo = (waits < 0) || (acc > TO);
`else
            tmo = 1'b0;
`endif
            if (tmo) begin
                e.rdata = '0; e.err = 1'b1; e.psel_cyc = TO + 1; e.pen_cyc = TO;
                last_rd = '0;
            end else begin
                if (w) begin
                    mmem[a] = d;
                    e.rdata = last_rd;
                end else begin
                    e.rdata = mmem[a];
                    last_rd = mmem[a];
                end
                e.err = 1'b0; e.psel_cyc = acc + 1; e.pen_cyc = acc;
            end
            rsp_q.push_back(e);
        end
        @(posedge pclk); #1;
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && n < 500) begin
            @(posedge pclk); #1;
            n++;
        end
        chk("drain_responses", 32'(rsp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        #3 presetn = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        last_rd = '0;
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        last_rd   = '0;
        for (int i = 0; i < 4; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end

        #12;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_psel", 32'(psel), 32'd0);
        chk("reset_penable", 32'(penable), 32'd0);
        chk("reset_pwrite", 32'(pwrite), 32'd0);
        chk("reset_paddr", 32'(paddr), 32'd0);
        chk("reset_pwdata", 32'(pwdata), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // directed: zero-wait write, then a 3-wait read of TX data
        issue(1'b1, REG_BAUD, 8'h1A, 0, 1'b1);  drain();
        issue(1'b1, REG_TXDATA, 8'h5C, 0, 1'b1); drain();
        issue(1'b0, REG_TXDATA, 8'h33, 3, 1'b1); drain();

        // back-to-back with cmd_valid held high
        issue(1'b1, 2'd1, 8'hC3, 0, 1'b1);
        issue(1'b0, 2'd1, 8'h00, 2, 1'b1);
        issue(1'b0, REG_BAUD, 8'h7E, 1, 1'b1);
        drain();

        // randomised stream, sometimes chained, sometimes with gaps
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 5)), 1'b1);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        // reset during ACCESS wait states: no response, clean restart
        issue(1'b1, 2'd3, 8'hE7, 10, 1'b0);
        cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        pulse_reset();
        issue(1'b0, 2'd3, 8'h00, 1, 1'b1); drain();

`ifdef APB_TIMEOUT_EN
        // slave never ready: abort after TO ACCESS cycles
        issue(1'b0, REG_TXDATA, 8'h00, -1, 1'b1); drain();
        // ready exactly on the limit cycle completes normally
        issue(1'b1, REG_TXDATA, 8'hA5, TO - 1, 1'b1); drain();
        issue(1'b0, REG_TXDATA, 8'h00, TO - 1, 1'b1); drain();
        issue(1'b0, REG_BAUD, 8'h00, TO - 2, 1'b1); drain();
`else
        // slave never ready: transfer stays pending indefinitely
        issue(1'b1, REG_TXDATA, 8'h99, -1, 1'b0);
        cmd_valid = 1'b0;
        repeat (100) @(posedge pclk);
        #1;
        chk("pending_psel", 32'(psel), 32'd1);
        chk("pending_penable", 32'(penable), 32'd1);
        chk("pending_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("pending_rsp_err", 32'(rsp_err), 32'd0);
        chk("pending_cmd_ready", 32'(cmd_ready), 32'd0);
        pulse_reset();
        issue(1'b0, REG_TXDATA, 8'h00, 0, 1'b1); drain();
`endif

        repeat (3) @(posedge pclk);
        chk("final_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_apb_master
